// File: rtl/nco_waveform_core.sv
// Numerically controlled oscillator core.
// A phase accumulator advances by the active tuning word every running cycle;
// the top OUT_W accumulator bits feed a two-stage pipeline that shapes the
// phase into square, sawtooth, triangle or reverse-sawtooth samples.
// Frequency, wave and duty are only taken from the inputs at accumulator
// wrap, so a register write never tears a period. Wave and duty then travel
// down the pipeline with their phase.
//
// Output qualification: sample_valid qualifies sample_out and square_out.
// There is no ready; the consumer takes a sample on every clk edge where
// sample_valid is high, and must ignore sample_out while it is low.
module nco_waveform_core #(
  parameter int ACC_W = 64,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       wave,
  input  logic [ACC_W-1:0] frequency,
  input  logic [OUT_W-1:0] duty_cycle,
  output logic [OUT_W-1:0] sample_out,
  output logic             square_out,
  output logic             sample_valid,
  output logic             wrap,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Parameters currently in use by the accumulator
  logic [ACC_W-1:0] act_freq;
  logic [OUT_W-1:0] act_duty;
  logic [1:0]       act_wave;

  // Accumulator and stage-1 pipeline registers
  logic [ACC_W-1:0] acc;
  logic [OUT_W-1:0] ph;
  logic [OUT_W-1:0] ph_duty;
  logic [1:0]       ph_wave;
  logic             v1;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             run_go;
  logic             load_params;
  logic [OUT_W-1:0] wave_val;
  logic [OUT_W-1:0] tri_up;

  // Exposed FSM state: 0 = IDLE, 1 = RUN
  assign state_dbg = (state_q == RUN);

  // One extra bit catches the carry-out of the modulo-2^ACC_W add
  assign sum    = {1'b0, acc} + {1'b0, act_freq};
  assign run_go = (state_q == RUN) && enable;
  assign carry  = run_go && sum[ACC_W];

  // Reload while idle, on the stop edge, at wrap, or every cycle when the
  // tuning word is zero (a zero word can never wrap and would lock forever)
  assign load_params = !run_go || carry || (act_freq == '0);

  // Triangle rising half is the doubled phase; the falling half is its mirror
  assign tri_up = {ph[OUT_W-2:0], 1'b0};

  // Shape the stage-1 phase according to the wave select that travelled with it
  always_comb begin
    wave_val = '0;
    case (ph_wave)
      2'b00:   wave_val = (ph < ph_duty) ? '1 : '0;
      2'b01:   wave_val = ph;
      2'b10:   wave_val = ph[OUT_W-1] ? ~tri_up : tri_up;
      default: wave_val = ~ph;
    endcase
  end

  // Next-state: run while enable is sampled high
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Active parameter capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_freq <= '0;
      act_duty <= '0;
      act_wave <= '0;
    end else if (load_params) begin
      act_freq <= frequency;
      act_duty <= duty_cycle;
      act_wave <= wave;
    end
  end

  // Accumulator and pipeline; anything other than a running edge clears it,
  // so RUN entry and exit both restart from phase zero and disable beats wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc          <= '0;
      ph           <= '0;
      ph_duty      <= '0;
      ph_wave      <= '0;
      v1           <= 1'b0;
      sample_out   <= '0;
      square_out   <= 1'b0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else if (run_go) begin
      acc          <= sum[ACC_W-1:0];
      ph           <= acc[ACC_W-1 -: OUT_W];
      ph_duty      <= act_duty;
      ph_wave      <= act_wave;
      v1           <= 1'b1;
      sample_out   <= wave_val;
      square_out   <= (ph < ph_duty);
      sample_valid <= v1;
      wrap         <= carry;
    end else begin
      acc          <= '0;
      ph           <= '0;
      ph_duty      <= '0;
      ph_wave      <= '0;
      v1           <= 1'b0;
      sample_out   <= '0;
      square_out   <= 1'b0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end
  end

endmodule

// File: doc/nco_waveform_core.md
Name: nco_waveform_core

Overview:
- Numerically controlled oscillator core, directly downstream of the I2C control slave.
- Consumes the slave's enable, wave, frequency (64-bit tuning word) and duty_cycle outputs and produces a registered 16-bit unsigned waveform sample plus a square/pulse bit.
- Parameter changes are applied glitch-free at phase-accumulator wrap, so a register write never produces a torn period.

Parameters:
ACC_W, 64, phase accumulator / tuning word width
OUT_W, 16, phase truncation and sample width (top OUT_W accumulator bits)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
enable  input  1  oscillator run request from the control slave
wave  input  2  waveform select: 00 square/pulse, 01 sawtooth, 10 triangle, 11 reverse sawtooth
frequency  input  ACC_W  tuning word added to the accumulator every running cycle
duty_cycle  input  OUT_W  square threshold; output high while phase < duty_cycle
sample_out  output  OUT_W  registered waveform sample
square_out  output  1  registered pulse bit (phase < active duty), valid in every wave mode
sample_valid  output  1  high while sample_out holds a running-mode sample
wrap  output  1  one-cycle pulse after the accumulator carries out

Behaviour:
- Reset: rst is asynchronous and active-low. While rst=0, state=IDLE, accumulator=0, all pipeline registers=0, sample_out=0, square_out=0, sample_valid=0 and wrap=0. Outputs clear immediately, even mid-run.
- States: IDLE and RUN.
  - IDLE: accumulator held at 0. Active params (act_freq, act_duty, act_wave) copy the inputs every cycle.
  - IDLE -> RUN on the first edge that samples enable=1. On that edge acc<=0 and the active params are loaded.
  - RUN -> IDLE on the first edge that samples enable=0. On that edge acc<=0, stage registers clear, sample_out<=0, square_out<=0, sample_valid<=0, wrap<=0. Disable wins over a simultaneous wrap.
- Accumulator (RUN): acc <= acc + act_freq, modulo 2^ACC_W. carry = carry-out of that add.
- Stage 1 (RUN): ph <= acc[ACC_W-1 -: OUT_W] using the pre-add acc. ph_wave<=act_wave, ph_duty<=act_duty, v1<=1.
- Stage 2: sample_out <= f(ph, ph_wave). square_out <= (ph < ph_duty). sample_valid <= v1.
- Waveform function f:
  - 00: 0xFFFF if ph < ph_duty, else 0x0000. duty 0 gives constantly low; duty 0xFFFF is low only at ph=0xFFFF.
  - 01: ph.
  - 10: ph[15]=0 gives {ph[14:0],0}; ph[15]=1 gives ~{ph[14:0],0}.
  - 11: ~ph.
- Latency: edge E0 enters RUN. After E1, ph=0. After E2, sample_out=f(0) and sample_valid=1. After E(k+1), sample_out=f(top bits of (k-1)*act_freq) for k>=1.
- Parameter update in RUN:
  - The active params reload from the inputs only on an edge where carry=1. That edge's add still uses the old act_freq; the next add uses the new one.
  - wave and duty travel with ph, so a sample always uses params consistent with its phase.
- act_freq=0 in RUN: no wrap can occur, so the active params reload every cycle.
- wrap: wrap<=carry, one cycle per overflow. A tuning word of 2^ACC_W-1 wraps on nearly every cycle and remains legal.
- Inputs are synchronous to clk. No CDC is required.
- The active params may reload on consecutive wrap edges; the last input value wins.

Test Plan:
1. Async reset mid-run: saw at step 1, drop rst between edges -> all outputs 0 before the next edge. Release rst with enable=1 -> first valid sample 0x0000 two edges after RUN entry.
2. Sawtooth: wave=01, frequency=2^48 -> sample_out 0,1,2,... After 65536 adds, wrap pulses once and the sequence restarts at 0.
3. Square: wave=00, frequency=2^60, duty=0x8000 -> repeating 8x0xFFFF, 8x0x0000. With duty=0x0000 -> constant 0 and square_out=0.
4. Triangle: wave=10, frequency=2^60 -> 0x0000,0x2000,...,0xE000,0xFFFF,0xDFFF,...,0x1FFF, then repeat.
5. Glitch-free update: saw at frequency=2^60, change frequency to 2^59 at phase 0x5000 -> steps of 0x1000 until the wrap pulse, then steps of 0x0800. wave change mid-period takes effect only after the wrap.
6. Enable/zero frequency:
   - Run with frequency=0 -> sample constant, no wrap. Writing 2^60 takes effect on the next edge.
   - Deassert enable coincident with carry -> next edge gives sample_valid=0, sample_out=0, wrap=0.
